multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the ARMv8 (LEGv8 subset) datapath.
- Replaces single-cycle decode: steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the shared ALU, register file and memory strobes one phase at a time.
- Handshakes with instruction and data memories of variable latency.
- Sits between the IR/PC registers and the datapath muxes.

Parameters:
- CNT_WIDTH, 32, width of the performance counters (used only with PERF_COUNT_EN).

Ports:
- CLK  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  11  IR[31:21]; sampled only in DECODE.
- zero  in  1  ALU zero flag; sampled in EXEC.
- imem_ready  in  1  instruction word valid, IR may be written.
- dmem_ready  in  1  data access complete (read data valid / write accepted).
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  update PC.
- pc_branch  out  1  PC source select: 1 = branch target, 0 = PC+4.
- reg2loc, alusrc, mem2reg  out  1 each  datapath mux selects.
- regwrite, memread, memwrite  out  1 each  write/access strobes.
- aluop  out  4  ALU operation.
- signop  out  3  immediate extend type.
- mov_sh  out  2  MOVZ shift.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- illegal  out  1  sticky: an unrecognised opcode was decoded.

Behaviour:
- Decode priority (x = don't care):
  - LDUR xx111000010
  - STUR xx111000000
  - ADD x0x01011xxx
  - SUB x1x01011xxx
  - AND x0001010xxx
  - ORR x0101010xxx
  - CBZ x011010xxxx
  - B x00101xxxxx
  - MOVZ 110100101xx
  - anything else is ILLEGAL.
- Decoded fields:
  - aluop: LDUR/STUR/ADD 0010, SUB 0110, AND 0000, ORR 0001, CBZ/B/MOVZ/ILLEGAL 0111.
  - signop: LDUR/STUR 001, B 010, CBZ 011, MOVZ 100, others 000.
  - reg2loc=1 for STUR and CBZ.
  - alusrc=1 for LDUR, STUR and MOVZ.
  - mem2reg=1 for LDUR.
  - mov_sh=opcode[1:0] for MOVZ, else 00.
- Decode register:
  - Written at the end of DECODE and held until the next DECODE.
  - Mux/ALU outputs are driven from it in DECODE (from live decode), EXEC, MEM and WB.
  - All mux/ALU outputs are 0 in FETCH.
- Strobes are combinational from state, the decode register and the ready inputs. All are 0 unless listed below.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_write=1, go to DECODE.
  - Otherwise stay in FETCH with imem_req held.
- DECODE:
  - Latch decode, go to EXEC.
  - On ILLEGAL: set illegal.
- EXEC, by class:
  - B: pc_write=1, pc_branch=1, go to FETCH.
  - CBZ: pc_write=1, pc_branch=zero, go to FETCH.
  - LDUR/STUR: go to MEM.
  - ADD/SUB/AND/ORR/MOVZ: go to WB.
  - ILLEGAL: pc_write=1, pc_branch=0 (skip the instruction), go to FETCH.
- MEM:
  - memread (LDUR) or memwrite (STUR) is held high until dmem_ready=1.
  - STUR on ready: pc_write=1, go to FETCH.
  - LDUR on ready: go to WB.
- WB: regwrite=1, pc_write=1, pc_branch=0, go to FETCH.
- Ready inputs are ignored in states that do not request them.
- Zero-wait latency:
  - B/CBZ/ILLEGAL: 3 cycles.
  - R-type/MOVZ/STUR: 4 cycles.
  - LDUR: 5 cycles.
  - Each memory wait cycle adds 1.
- Reset:
  - While reset=1, every strobe (imem_req, ir_write, pc_write, regwrite, memread, memwrite) is forced to 0, even mid-MEM.
  - Next state is FETCH; decode register and illegal are cleared.
  - Reset asserted mid-instruction aborts it with no architectural write.
- illegal clears only on reset.
- pc_write and regwrite are never high in the same cycle except in WB.

Optional Feature:
- Macro PERF_COUNT_EN.
- When defined, adds outputs:
  - cycle_count (CNT_WIDTH): increments every non-reset cycle.
  - instr_count (CNT_WIDTH): increments on every cycle with pc_write=1.
- Both clear on reset and wrap modulo 2^CNT_WIDTH.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- ADD, imem_ready always 1 -> state sequence 0,1,2,4,0; aluop=0010 from DECODE; regwrite=pc_write=1 only in the WB cycle.
- LDUR with dmem_ready low 3 cycles -> memread high 4 cycles in MEM; then WB with mem2reg=1 and regwrite=1; total 8 cycles.
- CBZ: zero=1 -> pc_branch=1 with pc_write in EXEC. CBZ: zero=0 -> pc_branch=0. Both return to FETCH after 3 cycles.
- opcode 11'b00000000000 -> illegal rises after DECODE; pc_write=1 in EXEC with no regwrite/memwrite; illegal stays 1 until reset.
- STUR with reset asserted on the second MEM cycle -> memwrite=0 in that cycle; state=FETCH next; illegal=0; no pc_write.
- PERF_COUNT_EN with CNT_WIDTH=4, 20 zero-wait B instructions -> instr_count=20 mod 16=4; cycle_count=60 mod 16=12.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for a LEGv8-subset datapath.
// Define PERF_COUNT_EN to add the cycle_count / instr_count performance counters.
module multicycle_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_branch,
    output logic        reg2loc,
    output logic        alusrc,
    output logic        mem2reg,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic [3:0]  aluop,
    output logic [2:0]  signop,
    output logic [1:0]  mov_sh,
    output logic [2:0]  state,
    output logic        illegal
`ifdef PERF_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        C_ILLEGAL = 4'd0,
        C_LDUR    = 4'd1,
        C_STUR    = 4'd2,
        C_ADD     = 4'd3,
        C_SUB     = 4'd4,
        C_AND     = 4'd5,
        C_ORR     = 4'd6,
        C_CBZ     = 4'd7,
        C_B       = 4'd8,
        C_MOVZ    = 4'd9
    } class_e;

    typedef struct packed {
        class_e     cls;
        logic [3:0] aluop;
        logic [2:0] signop;
        logic       reg2loc;
        logic       alusrc;
        logic       mem2reg;
        logic [1:0] mov_sh;
    } dec_t;

    state_e r_state;
    state_e w_next;
    dec_t   r_dec;
    dec_t   w_dec;
    dec_t   w_fld;
    logic   r_illegal;

    logic   w_imem_req;
    logic   w_ir_write;
    logic   w_pc_write;
    logic   w_pc_branch;
    logic   w_regwrite;
    logic   w_memread;
    logic   w_memwrite;

    // Live decode of IR[31:21]; case order is the match priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        w_dec       = '0;
        w_dec.cls   = C_ILLEGAL;
        w_dec.aluop = 4'b0111;
        casez (opcode)
            11'b??111000010: begin
                w_dec.cls     = C_LDUR;
                w_dec.aluop   = 4'b0010;
                w_dec.signop  = 3'b001;
                w_dec.alusrc  = 1'b1;
                w_dec.mem2reg = 1'b1;
            end
            11'b??111000000: begin
                w_dec.cls     = C_STUR;
                w_dec.aluop   = 4'b0010;
                w_dec.signop  = 3'b001;
                w_dec.reg2loc = 1'b1;
                w_dec.alusrc  = 1'b1;
            end
            11'b?0?01011???: begin
                w_dec.cls   = C_ADD;
                w_dec.aluop = 4'b0010;
            end
            11'b?1?01011???: begin
                w_dec.cls   = C_SUB;
                w_dec.aluop = 4'b0110;
            end
            11'b?0001010???: begin
                w_dec.cls   = C_AND;
                w_dec.aluop = 4'b0000;
            end
            11'b?0101010???: begin
                w_dec.cls   = C_ORR;
                w_dec.aluop = 4'b0001;
            end
            11'b?011010????: begin
                w_dec.cls     = C_CBZ;
                w_dec.signop  = 3'b011;
                w_dec.reg2loc = 1'b1;
            end
            11'b?00101?????: begin
                w_dec.cls    = C_B;
                w_dec.signop = 3'b010;
            end
            11'b110100101??: begin
                w_dec.cls    = C_MOVZ;
                w_dec.signop = 3'b100;
                w_dec.alusrc = 1'b1;
                w_dec.mov_sh = opcode[1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments make every register update see pre-edge values, independent of statement order.
        if (reset) begin
            r_state   <= S_FETCH;
            r_dec     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_dec <= w_dec;
                if (w_dec.cls == C_ILLEGAL) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_fld       = r_dec;
        w_imem_req  = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_branch = 1'b0;
        w_regwrite  = 1'b0;
        w_memread   = 1'b0;
        w_memwrite  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_fld      = '0;
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_ir_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                w_fld  = w_dec;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                case (r_dec.cls)
                    C_B: begin
                        w_pc_write  = 1'b1;
                        w_pc_branch = 1'b1;
                        w_next      = S_FETCH;
                    end
                    C_CBZ: begin
                        w_pc_write  = 1'b1;
                        w_pc_branch = zero;
                        w_next      = S_FETCH;
                    end
                    C_ILLEGAL: begin
                        w_pc_write = 1'b1;
                        w_next     = S_FETCH;
                    end
                    C_LDUR, C_STUR: w_next = S_MEM;
                    default:        w_next = S_WB;
                endcase
            end
            S_MEM: begin
                w_memread  = (r_dec.cls == C_LDUR);
                w_memwrite = (r_dec.cls == C_STUR);
                if (dmem_ready) begin
                    if (r_dec.cls == C_STUR) begin
                        w_pc_write = 1'b1;
                        w_next     = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_regwrite = 1'b1;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset suppresses every strobe immediately so an aborted instruction writes nothing.
    assign imem_req  = w_imem_req & ~reset;
    assign ir_write  = w_ir_write & ~reset;
    assign pc_write  = w_pc_write & ~reset;
    assign regwrite  = w_regwrite & ~reset;
    assign memread   = w_memread  & ~reset;
    assign memwrite  = w_memwrite & ~reset;
    assign pc_branch = w_pc_branch;

    assign reg2loc = w_fld.reg2loc;
    assign alusrc  = w_fld.alusrc;
    assign mem2reg = w_fld.mem2reg;
    assign aluop   = w_fld.aluop;
    assign signop  = w_fld.signop;
    assign mov_sh  = w_fld.mov_sh;
    assign state   = r_state;
    assign illegal = r_illegal;

`ifdef PERF_COUNT_EN
    logic [CNT_WIDTH-1:0] r_cycle_count;
    logic [CNT_WIDTH-1:0] r_instr_count;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
            if (pc_write) begin
                r_instr_count <= r_instr_count + CNT_WIDTH'(1);
            end
        end
    end

    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against a per-instruction phase model.
// Counter checks are active when PERF_COUNT_EN is defined (CNT_WIDTH = 4 here).
module tb_multicycle_control;

    localparam int CW = 4;

    logic          CLK        = 1'b0;
    logic          reset      = 1'b1;
    logic [10:0]   opcode     = '0;
    logic          zero       = 1'b0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, ir_write, pc_write, pc_branch;
    logic          reg2loc, alusrc, mem2reg, regwrite, memread, memwrite;
    logic [3:0]    aluop;
    logic [2:0]    signop;
    logic [1:0]    mov_sh;
    logic [2:0]    state;
    logic          illegal;
`ifdef PERF_COUNT_EN
    logic [CW-1:0] cycle_count, instr_count;
`endif

    multicycle_control #(.CNT_WIDTH(CW)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_branch  (pc_branch),
        .reg2loc    (reg2loc),
        .alusrc     (alusrc),
        .mem2reg    (mem2reg),
        .regwrite   (regwrite),
        .memread    (memread),
        .memwrite   (memwrite),
        .aluop      (aluop),
        .signop     (signop),
        .mov_sh     (mov_sh),
        .state      (state),
        .illegal    (illegal)
`ifdef PERF_COUNT_EN
        ,
        .cycle_count(cycle_count),
        .instr_count(instr_count)
`endif
    );

    always #5 CLK = ~CLK;

    typedef enum int {K_LDUR, K_STUR, K_ADD, K_SUB, K_AND, K_ORR, K_CBZ, K_B, K_MOVZ, K_ILL} kind_e;

    // Opcode patterns as mask/value pairs, listed in match priority order.
    localparam logic [10:0] PAT_MASK [9] = '{
        11'b00111111111, 11'b00111111111, 11'b01011111000, 11'b01011111000, 11'b01111111000,
        11'b01111111000, 11'b01111110000, 11'b01111100000, 11'b11111111100};
    localparam logic [10:0] PAT_VAL [9] = '{
        11'b00111000010, 11'b00111000000, 11'b00001011000, 11'b01001011000, 11'b00001010000,
        11'b00101010000, 11'b00110100000, 11'b00010100000, 11'b11010010100};

    int            n_checks = 0;
    int            n_fail   = 0;
    bit            m_illegal = 1'b0;
    logic [CW-1:0] m_cyc   = '0;
    logic [CW-1:0] m_instr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    function automatic kind_e classify(input logic [10:0] op);
        for (int i = 0; i < 9; i++) begin
            if ((op & PAT_MASK[i]) == PAT_VAL[i]) return kind_e'(i);
        end
        return K_ILL;
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    // Expected packed output word for one cycle of a given phase.
    function automatic logic [31:0] expect_vec(input int st, input kind_e k, input logic [10:0] op,
                                               input bit rst, input bit ird, input bit drd,
                                               input bit z, input bit illg);
        bit req = 0, irw = 0, pcw = 0, pcb = 0, rw = 0, mr = 0, mw = 0;
        bit r2l = 0, asrc = 0, m2r = 0;
        logic [3:0] alu = 4'b0000;
        logic [2:0] sg = 3'b000;
        logic [1:0] msh = 2'b00;
        logic [2:0] st3 = 3'(st);
        if (st != 0) begin
            case (k)
                K_LDUR, K_STUR, K_ADD: alu = 4'b0010;
                K_SUB:                 alu = 4'b0110;
                K_AND:                 alu = 4'b0000;
                K_ORR:                 alu = 4'b0001;
                default:               alu = 4'b0111;
            endcase
            case (k)
                K_LDUR, K_STUR: sg = 3'b001;
                K_B:            sg = 3'b010;
                K_CBZ:          sg = 3'b011;
                K_MOVZ:         sg = 3'b100;
                default:        sg = 3'b000;
            endcase
            r2l  = (k == K_STUR) || (k == K_CBZ);
            asrc = (k == K_LDUR) || (k == K_STUR) || (k == K_MOVZ);
            m2r  = (k == K_LDUR);
            msh  = (k == K_MOVZ) ? op[1:0] : 2'b00;
        end
        case (st)
            0: begin req = 1; irw = ird; end
            2: begin
                if (k == K_B)   begin pcw = 1; pcb = 1; end
                if (k == K_CBZ) begin pcw = 1; pcb = z; end
                if (k == K_ILL) pcw = 1;
            end
            3: begin
                mr  = (k == K_LDUR);
                mw  = (k == K_STUR);
                pcw = (k == K_STUR) && drd;
            end
            4: begin rw = 1; pcw = 1; end
            default: ;
        endcase
        if (rst) begin
            req = 0; irw = 0; pcw = 0; rw = 0; mr = 0; mw = 0;
        end
        return {9'b0, st3, illg, req, irw, pcw, pcb, r2l, asrc, m2r, rw, mr, mw, alu, sg, msh};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {9'b0, state, illegal, imem_req, ir_write, pc_write, pc_branch, reg2loc, alusrc,
                mem2reg, regwrite, memread, memwrite, aluop, signop, mov_sh};
    endfunction

    // One clock: drive at negedge, compare shortly after, then advance the model across the edge.
    // The opcode bus carries the instruction only in DECODE and noise everywhere else.
    task automatic step(input string tag, input int st, input kind_e k, input logic [10:0] op,
                        input bit rst, input bit ird, input bit drd, input bit z);
        logic [31:0] exp;
        @(negedge CLK);
        reset      = rst;
        imem_ready = ird;
        dmem_ready = drd;
        zero       = z;
        opcode     = (st == 1) ? op : 11'($urandom);
        #1;
        exp = expect_vec(st, k, op, rst, ird, drd, z, m_illegal);
        check(tag, obs_vec(), exp);
        if (rst) begin
            m_illegal = 1'b0;
            m_cyc     = '0;
            m_instr   = '0;
        end else begin
            m_cyc = m_cyc + CW'(1);
            if (exp[16]) m_instr = m_instr + CW'(1);
            if (st == 1 && k == K_ILL) m_illegal = 1'b1;
        end
    endtask

    task automatic run_instr(input logic [10:0] op, input bit z, input int fw, input int mw);
        kind_e k = classify(op);
        for (int i = 0; i <= fw; i++) step("fetch", 0, k, op, 1'b0, (i == fw), rb(), rb());
        step("decode", 1, k, op, 1'b0, rb(), rb(), rb());
        step("exec", 2, k, op, 1'b0, rb(), rb(), z);
        if (k == K_LDUR || k == K_STUR) begin
            for (int i = 0; i <= mw; i++) step("mem", 3, k, op, 1'b0, rb(), (i == mw), rb());
        end
        if (k inside {K_LDUR, K_ADD, K_SUB, K_AND, K_ORR, K_MOVZ}) begin
            step("wb", 4, k, op, 1'b0, rb(), rb(), rb());
        end
    endtask

    task automatic check_counters(input string tag);
`ifdef PERF_COUNT_EN
        @(posedge CLK);
        #1;
        check({tag, "_cycle_count"}, 32'(cycle_count), 32'(m_cyc));
        check({tag, "_instr_count"}, 32'(instr_count), 32'(m_instr));
`else
        if (tag.len() == 0) $display("empty counter tag");
`endif
    endtask

    function automatic logic [10:0] rand_op();
        int idx = $urandom_range(0, 9);
        if (idx == 9) return 11'($urandom);
        return (11'($urandom) & ~PAT_MASK[idx]) | PAT_VAL[idx];
    endfunction

    function automatic int rand_wait();
        return ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
    endfunction

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_MOVZ = 11'b11010010101;
    localparam logic [10:0] OP_ILL  = 11'b00000000000;

    initial begin
        step("reset", 0, K_ILL, OP_ILL, 1'b1, 1'b1, 1'b1, 1'b1);
        step("reset", 0, K_ILL, OP_ILL, 1'b1, 1'b1, 1'b1, 1'b1);

        run_instr(OP_ADD, 1'b0, 0, 0);
        run_instr(OP_LDUR, 1'b0, 0, 3);
        run_instr(OP_CBZ, 1'b1, 0, 0);
        run_instr(OP_CBZ, 1'b0, 0, 0);
        run_instr(OP_MOVZ, 1'b0, 2, 0);
        run_instr(OP_STUR, 1'b0, 1, 2);

        // Illegal instruction, then a STUR aborted by reset on its second MEM cycle.
        run_instr(OP_ILL, 1'b0, 0, 0);
        run_instr(OP_ADD, 1'b1, 0, 0);
        step("stur_fetch", 0, K_STUR, OP_STUR, 1'b0, 1'b1, 1'b0, 1'b0);
        step("stur_decode", 1, K_STUR, OP_STUR, 1'b0, 1'b0, 1'b0, 1'b0);
        step("stur_exec", 2, K_STUR, OP_STUR, 1'b0, 1'b0, 1'b0, 1'b0);
        step("stur_mem1", 3, K_STUR, OP_STUR, 1'b0, 1'b0, 1'b0, 1'b0);
        step("stur_mem2_rst", 3, K_STUR, OP_STUR, 1'b1, 1'b1, 1'b1, 1'b0);
        run_instr(OP_ADD, 1'b0, 0, 0);

        // Twenty zero-wait branches from a fresh reset: counters wrap at 16.
        step("reset_b", 0, K_ILL, OP_ILL, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) run_instr(OP_B, rb(), 0, 0);
        check_counters("b20");

        for (int n = 0; n < 200; n++) begin
            if (n % 40 == 39) step("reset_rand", 0, K_ILL, OP_ILL, 1'b1, rb(), rb(), rb());
            run_instr(rand_op(), rb(), rand_wait(), rand_wait());
        end
        check_counters("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
